// File: rtl/alu_pkg.sv
// Constants and signed-range helpers shared by the adder stages and the result buffer.
package alu_pkg;

    localparam int ALU_SIZE = 8;

    // Bit patterns of the extreme w-bit signed values, zero-extended to 64 bits (w <= 64).
    function automatic logic [63:0] smax(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] smin(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/sat_narrow.sv
// Narrows a SIZE+1 bit signed sum to SIZE bits, clamping or truncating out-of-range values.
module sat_narrow
    import alu_pkg::*;
#(
    parameter int SIZE     = ALU_SIZE,
    parameter bit SATURATE = 1'b1
) (
    input  logic [SIZE:0]   sum,
    output logic [SIZE-1:0] data,
    output logic            saturated
);

    localparam logic [SIZE-1:0] MAXV = SIZE'(smax(SIZE));
    localparam logic [SIZE-1:0] MINV = SIZE'(smin(SIZE));

    // The top two bits disagree exactly when the value does not fit in SIZE signed bits.
    assign saturated = sum[SIZE] ^ sum[SIZE-1];

    always_comb begin
        data = sum[SIZE-1:0];
        if (SATURATE && saturated) begin
            data = sum[SIZE] ? MINV : MAXV;
        end
    end

endmodule

// File: rtl/sum_result_buffer.sv
// Two-entry result FIFO behind the signed adder: narrows each sum on push and counts
// entries that saturated or overflowed.
module sum_result_buffer
    import alu_pkg::*;
#(
    parameter int SIZE     = ALU_SIZE,
    parameter bit SATURATE = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE:0]   in_result,
    input  logic            in_overflow,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_data,
    output logic            out_overflow,
    output logic            out_saturated,
    input  logic            clear_count,
    output logic [7:0]      ovf_count
);

    logic [SIZE-1:0] data_q [2];
    logic            ovf_q  [2];
    logic            sat_q  [2];

    logic [1:0] count_q, count_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    logic [SIZE-1:0] nar_data;
    logic            nar_sat;
    logic            push, pop;

    sat_narrow #(
        .SIZE     (SIZE),
        .SATURATE (SATURATE)
    ) u_narrow (
        .sum       (in_result),
        .data      (nar_data),
        .saturated (nar_sat)
    );

    // Handshake flags come from the occupancy register only, so out_ready never reaches in_ready.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_data      = data_q[rd_ptr_q];
    assign out_overflow  = ovf_q[rd_ptr_q];
    assign out_saturated = sat_q[rd_ptr_q];
    assign ovf_count     = ovf_cnt_q;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
    end

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (clear_count) begin
            ovf_cnt_d = 8'd0;
        end else if (push && (nar_sat || in_overflow) && ovf_cnt_q != 8'hFF) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= 2'd0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            ovf_cnt_q <= 8'd0;
        end else begin
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    // Payload storage is qualified by occupancy, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= nar_data;
            ovf_q[wr_ptr_q]  <= in_overflow;
            sat_q[wr_ptr_q]  <= nar_sat;
        end
    end

endmodule
